// File: rtl/seqdet_pkg.sv
// Shared constants and helpers for the parametrised serial-pattern detector.
package seqdet_pkg;

  localparam int         MAX_PAT_W       = 16;
  localparam logic [4:0] DEFAULT_PATTERN = 5'b10110;

  function automatic int state_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // The newest bit sits at window[0]. pattern_top holds the first k pattern bits right-aligned.
  function automatic logic prefix_eq(input logic [MAX_PAT_W-1:0] window,
                                     input logic [MAX_PAT_W-1:0] pattern_top,
                                     input int                   k);
    logic eq;
    eq = 1'b1;
    for (int i = 0; i < MAX_PAT_W; i++) begin
      if (i < k && window[i] != pattern_top[i]) eq = 1'b0;
    end
    return eq;
  endfunction

endpackage

// File: rtl/seqdet_next_state.sv
// Combinational next-state search. It returns the longest pattern prefix, no longer
// than base+1, that ends at the newest bit.
module seqdet_next_state
  import seqdet_pkg::*;
#(
  parameter int PAT_W = 5,
  parameter int SW    = state_w(PAT_W)
) (
  input  logic [PAT_W-2:0] history,
  input  logic             in_bit,
  input  logic [PAT_W-1:0] pattern,
  input  logic [SW-1:0]    base,
  output logic [SW-1:0]    next_k
);

  logic [MAX_PAT_W-1:0] window;
  logic [MAX_PAT_W-1:0] pat_ext;

  // Ascending scan. The last hit wins, so the longest qualifying prefix has priority.
  always_comb begin
    window  = MAX_PAT_W'({history, in_bit});
    pat_ext = MAX_PAT_W'(pattern);
    next_k  = '0;
    for (int k = 1; k <= PAT_W; k++) begin
      if (k <= int'(base) + 1 && prefix_eq(window, pat_ext >> (PAT_W - k), k))
        next_k = SW'(k);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Moore detector for a run-time-loadable PAT_W-bit pattern, received MSB first.
// It also keeps a saturating match counter.
//   state     | meaning
//   0         | no pattern bits matched
//   1..PAT_W-1| last k bits equal the first k pattern bits
//   PAT_W     | full match; out rises on the following edge
module seq_detector_param
  import seqdet_pkg::*;
#(
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEFAULT_PATTERN),
  parameter int               CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      in_bit,
  input  logic                      cfg_load,
  input  logic [PAT_W-1:0]          cfg_pattern,
  input  logic                      cfg_overlap,
  input  logic                      cnt_clr,
  output logic                      out,
  output logic [state_w(PAT_W)-1:0] state,
  output logic [CNT_W-1:0]          match_count
);

  localparam int               SW      = state_w(PAT_W);
  localparam logic [SW-1:0]    FULL    = SW'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [SW-1:0]    state_q, state_d;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SW-1:0]    base;
  logic [SW-1:0]    next_k;
  logic [PAT_W-1:0] window;
  logic             match_entry;

  // In non-overlap mode, a completed match restarts the search from scratch.
  assign base   = (state_q == FULL && !cfg_overlap) ? '0 : state_q;
  assign window = {hist_q, in_bit};

  seqdet_next_state #(.PAT_W(PAT_W), .SW(SW)) u_next (
    .history (hist_q),
    .in_bit  (in_bit),
    .pattern (pattern_q),
    .base    (base),
    .next_k  (next_k)
  );

  assign match_entry = !cfg_load && in_valid && (next_k == FULL);

  always_comb begin
    pattern_d = pattern_q;
    hist_d    = hist_q;
    state_d   = state_q;
    out_d     = (state_q == FULL);
    cnt_d     = cnt_q;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      hist_d    = '0;
      state_d   = '0;
      out_d     = 1'b0;
    end else if (in_valid) begin
      hist_d  = window[PAT_W-2:0];
      state_d = next_k;
    end
    if (cnt_clr)
      cnt_d = '0;
    else if (match_entry && cnt_q != CNT_MAX)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= PATTERN;
      hist_q    <= '0;
      state_q   <= '0;
      out_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pattern_q <= pattern_d;
      hist_q    <= hist_d;
      state_q   <= state_d;
      out_q     <= out_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out         = out_q;
  assign state       = state_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench: a default 10110 detector, plus a 3-bit 101 detector with a 2-bit counter.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_bit = 1'b0, cfg_load = 1'b0;
  logic       cfg_overlap = 1'b1, cnt_clr = 1'b0;
  logic [4:0] cfg_pattern_a = '0;
  logic [2:0] cfg_pattern_b = '0;

  logic       out_a, out_b;
  logic [2:0] state_a;
  logic [1:0] state_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int passed = 0, failed = 0, total = 0;

  always #5 clk = ~clk;

  seq_detector_param dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern_a), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .out(out_a), .state(state_a), .match_count(cnt_a)
  );

  seq_detector_param #(.PAT_W(3), .PATTERN(3'b101), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern_b), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .out(out_b), .state(state_b), .match_count(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] s1;
    logic [9:0] s2;
    logic [4:0] s5;
    int exp1[6];
    int exp2[10];
    s1 = 6'b101100;
    s2 = 10'b1011010110;
    s5 = 5'b10101;
    exp1 = '{1, 2, 3, 4, 5, 0};
    exp2 = '{1, 2, 3, 4, 5, 3, 2, 3, 4, 5};

    // Reset and basic detection
    do_reset();
    chk("rst_state", state_a, 0);
    chk("rst_out", out_a, 0);
    chk("rst_cnt", cnt_a, 0);
    for (int i = 0; i < 6; i++) begin
      bit_in(s1[5-i]);
      chk($sformatf("t1_state%0d", i), state_a, exp1[i]);
      chk($sformatf("t1_out%0d", i), out_a, (i == 5));
    end
    chk("t1_cnt", cnt_a, 1);

    // Overlapping 10110
    do_reset();
    cfg_overlap = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bit_in(s2[9-i]);
      chk($sformatf("t2_state%0d", i), state_a, exp2[i]);
    end
    chk("t2_cnt", cnt_a, 2);

    // 101 on a 10101 stream, with and without overlap
    do_reset();
    for (int i = 0; i < 5; i++) bit_in(s5[4-i]);
    chk("t2b_ov_state", state_b, 3);
    chk("t2b_ov_cnt", cnt_b, 2);
    do_reset();
    cfg_overlap = 1'b0;
    for (int i = 0; i < 5; i++) bit_in(s5[4-i]);
    chk("t2b_nov_state", state_b, 1);
    chk("t2b_nov_cnt", cnt_b, 1);

    // Gaps between bits
    do_reset();
    cfg_overlap = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bit_in(s1[5-i]);
      chk($sformatf("t3_state%0d", i), state_a, i + 1);
      repeat (3) tick();
      chk($sformatf("t3_hold%0d", i), state_a, i + 1);
      chk($sformatf("t3_out%0d", i), out_a, (i == 4));
    end
    chk("t3_cnt", cnt_a, 1);

    // Reload mid-stream: the load cycle drops its bit and leaves the count alone
    cfg_overlap = 1'b0;
    bit_in(1'b1);
    bit_in(1'b0);
    bit_in(1'b1);
    chk("t4_pre_state", state_a, 3);
    cfg_load      = 1'b1;
    cfg_pattern_a = 5'b11100;
    in_valid      = 1'b1;
    in_bit        = 1'b1;
    tick();
    cfg_load = 1'b0;
    in_valid = 1'b0;
    chk("t4_load_state", state_a, 0);
    chk("t4_load_out", out_a, 0);
    chk("t4_load_cnt", cnt_a, 1);
    bit_in(1'b1);
    bit_in(1'b1);
    chk("t4_state2", state_a, 2);
    bit_in(1'b1);
    bit_in(1'b0);
    bit_in(1'b0);
    chk("t4_state5", state_a, 5);
    chk("t4_cnt", cnt_a, 2);
    tick();
    chk("t4_out", out_a, 1);

    // Saturation of the 2-bit counter, then clear beating an increment
    do_reset();
    cfg_overlap = 1'b0;
    for (int m = 0; m < 5; m++) begin
      bit_in(1'b1);
      bit_in(1'b0);
      bit_in(1'b1);
    end
    chk("t5_sat_state", state_b, 3);
    chk("t5_sat_cnt", cnt_b, 3);
    bit_in(1'b1);
    bit_in(1'b0);
    cnt_clr = 1'b1;
    bit_in(1'b1);
    cnt_clr = 1'b0;
    chk("t5_clr_state", state_b, 3);
    chk("t5_clr_cnt", cnt_b, 0);
    bit_in(1'b1);
    bit_in(1'b0);
    bit_in(1'b1);
    chk("t5_recount", cnt_b, 1);

    // Mid-match reset restores the default pattern
    do_reset();
    cfg_load      = 1'b1;
    cfg_pattern_a = 5'b11100;
    tick();
    cfg_load    = 1'b0;
    cfg_overlap = 1'b1;
    bit_in(1'b1); bit_in(1'b1); bit_in(1'b1); bit_in(1'b0); bit_in(1'b0);
    cfg_overlap = 1'b0;
    bit_in(1'b1); bit_in(1'b1); bit_in(1'b1); bit_in(1'b0);
    chk("t6_pre_state", state_a, 4);
    chk("t6_pre_cnt", cnt_a, 1);
    do_reset();
    chk("t6_rst_state", state_a, 0);
    chk("t6_rst_out", out_a, 0);
    chk("t6_rst_cnt", cnt_a, 0);
    bit_in(1'b0);
    chk("t6_tail_state", state_a, 0);
    chk("t6_tail_cnt", cnt_a, 0);
    for (int i = 0; i < 5; i++) bit_in(s1[5-i]);
    chk("t6_default_state", state_a, 5);
    chk("t6_default_cnt", cnt_a, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
